// File: rtl/serdes_pkg.sv
// Shared SerDes definitions: PRBS checker FSM states, PRBS7 polynomial taps
// (x^7 + x^6 + 1) and the widths of the checker's statistics counters.
package serdes_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // PRBS7: state s[6:0], next bit = s[6] ^ s[5], shift left inserting at s[0]
  localparam int unsigned Prbs7Order = 7;
  localparam int unsigned Prbs7TapHi = 6;
  localparam int unsigned Prbs7TapLo = 5;

  localparam int unsigned BitCountW  = 48;
  localparam int unsigned ErrCountW  = 32;
  localparam int unsigned LossCountW = 8;

endpackage

// File: rtl/prbs_predictor.sv
// Combinational PRBS7 next-bit predictor, shared by the TX generator and the
// RX checker so both sides use the same polynomial.
//   state    : current 7-bit PRBS state (s[0] is the newest bit)
//   next_bit : s[6] ^ s[5]
module prbs_predictor
  import serdes_pkg::*;
(
  input  logic [Prbs7Order-1:0] state,
  output logic                  next_bit
);

  assign next_bit = state[Prbs7TapHi] ^ state[Prbs7TapLo];

endmodule

// File: rtl/prbs_checker.sv
// PRBS7 bit-error-rate checker with SEARCH -> VERIFY -> LOCKED acquisition,
// windowed loss-of-lock detection and saturating statistics.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : enable; when low samples are ignored and state holds
//   clear           : synchronous clear of counters, back to SEARCH
//   data_in(_valid) : recovered bit and its qualifier
//   locked          : high while in LOCKED
//   err_pulse       : one-cycle pulse per error counted in LOCKED
//   bit_count       : bits checked while LOCKED
//   err_count       : bit errors while LOCKED
//   lock_loss_count : LOCKED -> SEARCH transitions
//   done            : sticky, set when bit_count reaches TARGET_BITS
module prbs_checker
  import serdes_pkg::*;
#(
  parameter int unsigned          PRBS_ORDER  = 7,
  parameter int unsigned          LOCK_COUNT  = 16,
  parameter int unsigned          WIN_LEN     = 64,
  parameter int unsigned          LOSS_THRESH = 8,
  parameter logic [BitCountW-1:0] TARGET_BITS = 48'h2FAF0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  data_in,
  input  logic                  data_in_valid,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [BitCountW-1:0]  bit_count,
  output logic [ErrCountW-1:0]  err_count,
  output logic [LossCountW-1:0] lock_loss_count,
  output logic                  done
);

  if (PRBS_ORDER != Prbs7Order) begin : g_bad_order
    $error("prbs_checker: only PRBS_ORDER = 7 is supported");
  end

  localparam int unsigned FillW   = $clog2(Prbs7Order + 1);
  localparam int unsigned MatchW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WinW    = $clog2(WIN_LEN + 1);
  localparam int unsigned WinErrW = $clog2(LOSS_THRESH + 1);

  // Terminal values: the sample that sees the counter at *Last completes it
  localparam logic [FillW-1:0]   FillLast   = FillW'(Prbs7Order - 1);
  localparam logic [MatchW-1:0]  MatchLast  = MatchW'(LOCK_COUNT - 1);
  localparam logic [WinW-1:0]    WinLast    = WinW'(WIN_LEN - 1);
  localparam logic [WinErrW-1:0] WinErrLast = WinErrW'(LOSS_THRESH - 1);

  chk_state_e            state_q;
  logic [Prbs7Order-1:0] prbs_q;
  logic [FillW-1:0]      fill_q;
  logic [MatchW-1:0]     match_q;
  logic [WinW-1:0]       win_cnt_q;
  logic [WinErrW-1:0]    win_err_q;

  logic                  pred_bit;
  logic                  accept;
  logic                  mismatch;
  logic [BitCountW-1:0]  bit_inc;
  logic [ErrCountW-1:0]  err_inc;
  logic [LossCountW-1:0] loss_inc;

  prbs_predictor u_pred (
    .state    (prbs_q),
    .next_bit (pred_bit)
  );

  always_comb begin
    accept   = en && data_in_valid && !done;
    mismatch = data_in ^ pred_bit;
    // Saturating increments
    bit_inc  = (bit_count == '1)       ? bit_count       : bit_count + 1'b1;
    err_inc  = (err_count == '1)       ? err_count       : err_count + 1'b1;
    loss_inc = (lock_loss_count == '1) ? lock_loss_count : lock_loss_count + 1'b1;
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= SEARCH;
      prbs_q          <= '0;
      fill_q          <= '0;
      match_q         <= '0;
      win_cnt_q       <= '0;
      win_err_q       <= '0;
      err_pulse       <= 1'b0;
      bit_count       <= '0;
      err_count       <= '0;
      lock_loss_count <= '0;
      done            <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        // Any sample arriving with clear is dropped
        state_q         <= SEARCH;
        prbs_q          <= '0;
        fill_q          <= '0;
        match_q         <= '0;
        win_cnt_q       <= '0;
        win_err_q       <= '0;
        bit_count       <= '0;
        err_count       <= '0;
        lock_loss_count <= '0;
        done            <= 1'b0;
      end else if (accept) begin
        unique case (state_q)
          SEARCH: begin
            prbs_q <= {prbs_q[Prbs7Order-2:0], data_in};
            if (fill_q == FillLast) begin
              state_q <= VERIFY;
              fill_q  <= '0;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          VERIFY: begin
            prbs_q <= {prbs_q[Prbs7Order-2:0], data_in};
            if (mismatch) begin
              state_q <= SEARCH;
              fill_q  <= '0;
            end else if (match_q == MatchLast) begin
              state_q   <= LOCKED;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so a bad bit cannot corrupt the state
            prbs_q    <= {prbs_q[Prbs7Order-2:0], pred_bit};
            bit_count <= bit_inc;
            if (bit_inc == TARGET_BITS) begin
              done <= 1'b1;
            end
            if (mismatch) begin
              err_count <= err_inc;
              err_pulse <= 1'b1;
            end
            if (mismatch && (win_err_q == WinErrLast)) begin
              state_q         <= SEARCH;
              fill_q          <= '0;
              lock_loss_count <= loss_inc;
              win_cnt_q       <= '0;
              win_err_q       <= '0;
            end else if (win_cnt_q == WinLast) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              if (mismatch) begin
                win_err_q <= win_err_q + 1'b1;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker. The driver pushes the expected outputs
// for every valid cycle it presents; the monitor pops one entry on the
// falling edge after each such cycle and compares. A second instance with
// TARGET_BITS = 200 covers the done/clear behaviour.
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clear, data_in, data_in_valid;

  logic        m_locked, m_pulse, m_done;
  logic [47:0] m_bits;
  logic [31:0] m_errs;
  logic [7:0]  m_loss;
  logic        t_locked, t_pulse, t_done;
  logic [47:0] t_bits;
  logic [31:0] t_errs;
  logic [7:0]  t_loss;

  prbs_checker dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .clear           (clear),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .locked          (m_locked),
    .err_pulse       (m_pulse),
    .bit_count       (m_bits),
    .err_count       (m_errs),
    .lock_loss_count (m_loss),
    .done            (m_done)
  );

  prbs_checker #(
    .TARGET_BITS (48'd200)
  ) dut_t (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .clear           (clear),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .locked          (t_locked),
    .err_pulse       (t_pulse),
    .bit_count       (t_bits),
    .err_count       (t_errs),
    .lock_loss_count (t_loss),
    .done            (t_done)
  );

  typedef struct {
    bit          sel;
    logic        lk;
    logic        pl;
    logic [47:0] bc;
    logic [31:0] ec;
    logic [7:0]  lc;
    logic        dn;
    int          tag;
  } exp_t;

  exp_t sb[$];

  int          vectors = 0;
  int          miscompares = 0;
  bit          sel = 1'b0;
  int          tag = 0;
  logic        e_lk, e_dn;
  logic [47:0] e_bc;
  logic [31:0] e_ec;
  logic [7:0]  e_lc;
  logic [6:0]  g;
  logic        pend = 1'b0;

  task automatic next_prbs(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic zero_exp();
    e_lk = 1'b0; e_bc = '0; e_ec = '0; e_lc = '0; e_dn = 1'b0;
  endtask

  task automatic send(input logic b, input logic en_v, input logic clr, input logic pulse);
    exp_t x;
    @(negedge clk);
    data_in = b; data_in_valid = 1'b1; en = en_v; clear = clr;
    x.sel = sel; x.lk = e_lk; x.pl = pulse; x.bc = e_bc; x.ec = e_ec;
    x.lc = e_lc; x.dn = e_dn; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0; en = 1'b1; clear = 1'b0; data_in = 1'b0;
    end
  endtask

  // Immediate (edge-free) check of the main instance against e_*
  task automatic check_now(input string name);
    vectors++;
    if (m_locked !== e_lk || m_pulse !== 1'b0 || m_bits !== e_bc || m_errs !== e_ec ||
        m_loss !== e_lc || m_done !== e_dn) begin
      miscompares++;
      $display("FAIL %s: got lk=%b pl=%b bc=%0d ec=%0d lc=%0d dn=%b, want lk=%b pl=0 bc=%0d ec=%0d lc=%0d dn=%b",
               name, m_locked, m_pulse, m_bits, m_errs, m_loss, m_done,
               e_lk, e_bc, e_ec, e_lc, e_dn);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_in_valid = 1'b0; clear = 1'b0; en = 1'b1; rst = 1'b1;
    zero_exp();
    g = 7'h7F;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 7 fill + 16 verify clean samples; counts held, locked on the last
  task automatic lock_up();
    logic b;
    for (int k = 1; k <= 23; k++) begin
      next_prbs(b);
      e_lk = (k == 23);
      send(b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  always @(posedge clk) pend <= data_in_valid;

  always @(negedge clk) begin
    if (pend) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: got empty queue, want an expected entry");
      end else begin
        exp_t        x;
        logic        a_lk, a_pl, a_dn;
        logic [47:0] a_bc;
        logic [31:0] a_ec;
        logic [7:0]  a_lc;
        x = sb.pop_front();
        if (x.sel) begin
          a_lk = t_locked; a_pl = t_pulse; a_bc = t_bits; a_ec = t_errs;
          a_lc = t_loss; a_dn = t_done;
        end else begin
          a_lk = m_locked; a_pl = m_pulse; a_bc = m_bits; a_ec = m_errs;
          a_lc = m_loss; a_dn = m_done;
        end
        if (a_lk !== x.lk || a_pl !== x.pl || a_bc !== x.bc || a_ec !== x.ec ||
            a_lc !== x.lc || a_dn !== x.dn) begin
          miscompares++;
          $display("FAIL vec scen=%0d: got lk=%b pl=%b bc=%0d ec=%0d lc=%0d dn=%b, want lk=%b pl=%b bc=%0d ec=%0d lc=%0d dn=%b",
                   x.tag, a_lk, a_pl, a_bc, a_ec, a_lc, a_dn,
                   x.lk, x.pl, x.bc, x.ec, x.lc, x.dn);
        end
      end
    end
  end

  initial begin
    logic b, inv;
    rst = 1'b1; en = 1'b1; clear = 1'b0; data_in = 1'b0; data_in_valid = 1'b0;
    zero_exp();
    #1 check_now("reset_state");

    // 1: clean stream, lock after 23, then 1000 error-free bits
    tag = 1;
    do_reset();
    lock_up();
    for (int i = 1; i <= 1000; i++) begin
      next_prbs(b);
      e_bc = 48'(i);
      send(b, 1'b1, 1'b0, 1'b0);
    end

    // 2: single inverted bit at locked bit 100, no propagation afterwards
    tag = 2;
    do_reset();
    lock_up();
    for (int i = 1; i <= 150; i++) begin
      next_prbs(b);
      inv = (i == 100);
      e_bc = 48'(i);
      if (inv) e_ec = 32'd1;
      send(b ^ inv, 1'b1, 1'b0, inv);
    end

    // 3: 8 errors in one window -> loss of lock, relock with counts retained
    tag = 3;
    do_reset();
    lock_up();
    for (int i = 1; i <= 25; i++) begin
      next_prbs(b);
      inv = (i >= 11) && (i % 2 == 1);
      e_bc = 48'(i);
      if (inv) e_ec = e_ec + 32'd1;
      if (i == 25) begin
        e_lk = 1'b0;
        e_lc = 8'd1;
      end
      send(b ^ inv, 1'b1, 1'b0, inv);
    end
    lock_up();
    for (int i = 1; i <= 10; i++) begin
      next_prbs(b);
      e_bc = 48'(25 + i);
      send(b, 1'b1, 1'b0, 1'b0);
    end

    // 4: TARGET_BITS = 200 instance: done, frozen counts, clear with valid
    tag = 4;
    sel = 1'b1;
    do_reset();
    lock_up();
    for (int i = 1; i <= 200; i++) begin
      next_prbs(b);
      e_bc = 48'(i);
      e_dn = (i == 200);
      send(b, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 5; i++) begin
      next_prbs(b);
      send(b ^ (i == 3), 1'b1, 1'b0, 1'b0);
    end
    zero_exp();
    next_prbs(b);
    send(b, 1'b1, 1'b1, 1'b0);
    lock_up();
    for (int i = 1; i <= 5; i++) begin
      next_prbs(b);
      e_bc = 48'(i);
      send(b, 1'b1, 1'b0, 1'b0);
    end
    sel = 1'b0;

    // 5: 1-in-3 valid, en dropped mid-VERIFY and mid-LOCKED
    tag = 5;
    do_reset();
    for (int k = 1; k <= 23; k++) begin
      idle(2);
      if (k == 13) begin
        for (int j = 0; j < 3; j++) send(~(g[6] ^ g[5]), 1'b0, 1'b0, 1'b0);
      end
      next_prbs(b);
      e_lk = (k == 23);
      send(b, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 20; i++) begin
      idle(2);
      if (i == 8) begin
        for (int j = 0; j < 2; j++) send(~(g[6] ^ g[5]), 1'b0, 1'b0, 1'b0);
      end
      next_prbs(b);
      e_bc = 48'(i);
      send(b, 1'b1, 1'b0, 1'b0);
    end

    // 6: async reset while LOCKED with err_pulse high
    tag = 6;
    do_reset();
    lock_up();
    for (int i = 1; i <= 10; i++) begin
      next_prbs(b);
      inv = (i == 10);
      e_bc = 48'(i);
      if (inv) e_ec = 32'd1;
      send(b ^ inv, 1'b1, 1'b0, inv);
    end
    idle(1);
    #2 rst = 1'b1;
    zero_exp();
    #1 check_now("async_reset_locked");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      next_prbs(b);
      send(b, 1'b1, 1'b0, 1'b0);
    end

    idle(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
